// File: rtl/div_mult_unit.sv
// Multicycle signed multiply / restoring divide, one bit per clock, result to HI/LO.
// Optional macro DIVMULT_EARLY_OUT_EN: MULT stops once the remaining multiplier is zero.
module div_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             zero_div_exception
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_EXC  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      abs_w = ~x + WIDTH'(1);
    end else begin
      abs_w = x;
    end
  endfunction

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   opa_q, opa_d;    // MULT: shifting multiplicand; DIV: dividend/quotient in low half
  logic [WIDTH-1:0]     opb_q, opb_d;    // MULT: shifting multiplier; DIV: divisor
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // MULT: product; DIV: remainder in low half
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sgn_quot_q, sgn_quot_d;
  logic                 sgn_rem_q, sgn_rem_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 zex_q, zex_d;

  logic [2*WIDTH-1:0]   mult_sum;
  logic [2*WIDTH-1:0]   mult_res;
  logic                 mult_last;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     div_rem;
  logic [WIDTH-1:0]     div_quot;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      opa_q      <= {(2*WIDTH){1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      cnt_q      <= {CW{1'b0}};
      sgn_quot_q <= 1'b0;
      sgn_rem_q  <= 1'b0;
      op_q       <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zex_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sgn_quot_q <= sgn_quot_d;
      sgn_rem_q  <= sgn_rem_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zex_q      <= zex_d;
    end
  end

  // One shift-add / restoring-subtract step on the current registers
  always_comb begin
    mult_sum = acc_q + (opb_q[0] ? opa_q : {(2*WIDTH){1'b0}});
    if (sgn_quot_q) begin
      mult_res = {(2*WIDTH){1'b0}} - mult_sum;
    end else begin
      mult_res = mult_sum;
    end
`ifdef DIVMULT_EARLY_OUT_EN
    mult_last = (cnt_q == LAST_ITER) || (opb_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    mult_last = (cnt_q == LAST_ITER);
`endif
    // Remainder < divisor <= 2^(W-1), so the shifted value never reaches bit W
    div_shift = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_diff[WIDTH]) begin
      div_rem = div_shift[WIDTH-1:0];
    end else begin
      div_rem = div_diff[WIDTH-1:0];
    end
    div_quot = {opa_q[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sgn_quot_d = sgn_quot_q;
    sgn_rem_d  = sgn_rem_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    zex_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op && (b == {WIDTH{1'b0}})) begin
            state_d = S_EXC;
            zex_d   = 1'b1;
          end else begin
            state_d    = S_RUN;
            busy_d     = 1'b1;
            opa_d      = {{WIDTH{1'b0}}, abs_w(a)};
            opb_d      = abs_w(b);
            acc_d      = {(2*WIDTH){1'b0}};
            cnt_d      = {CW{1'b0}};
            sgn_quot_d = a[WIDTH-1] ^ b[WIDTH-1];
            sgn_rem_d  = a[WIDTH-1];
            op_d       = op;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (!op_q) begin
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          acc_d = mult_sum;
          if (mult_last) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hi_d    = mult_res[2*WIDTH-1:WIDTH];
            lo_d    = mult_res[WIDTH-1:0];
          end else begin
            state_d = S_RUN;
          end
        end else begin
          opa_d = {{WIDTH{1'b0}}, div_quot};
          acc_d = {{WIDTH{1'b0}}, div_rem};
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            lo_d    = sgn_quot_q ? ({WIDTH{1'b0}} - div_quot) : div_quot;
            hi_d    = sgn_rem_q ? ({WIDTH{1'b0}} - div_rem) : div_rem;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign hi                 = hi_q;
  assign lo                 = lo_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign zero_div_exception = zex_q;

endmodule

// File: tb/tb_div_mult_unit.sv
// Directed table-driven bench for div_mult_unit, plus divide-by-zero, re-start and reset-abort sequences.
module tb_div_mult_unit;
  localparam int W = 32;
  localparam int NV = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         zero_div_exception;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done),
    .zero_div_exception(zero_div_exception)
  );

  typedef struct {
    logic         opv;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    int           lat_full;
    int           lat_early;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input int full, input int early);
`ifdef DIVMULT_EARLY_OUT_EN
    pick_lat = early;
`else
    pick_lat = full;
`endif
  endfunction

  // Start one operation; optionally re-pulse start (with other operands) at cycle 'glitch'
  task automatic run_op(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int glitch,
                        output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                        output int lat, output int bcnt, output int dcnt, output int zcnt);
    @(negedge clk);
    start = 1'b1; op = opv; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; bcnt = 0; zcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (zero_div_exception) zcnt++;
      if (lat == glitch) begin
        start = 1'b1; op = ~opv; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    rhi = hi; rlo = lo;
    dcnt = done ? 1 : 0;
    @(posedge clk); #1;
    if (done) dcnt++;
  endtask

  initial begin
    logic [W-1:0] rhi, rlo, prev_hi, prev_lo;
    int lat, bcnt, dcnt, zcnt, el;

    vecs[0]  = '{1'b0, 32'd3,         32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 32, 3};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32, 32};
    vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32, 32};
    vecs[3]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 32, 32};
    vecs[4]  = '{1'b0, 32'd3,         32'd5,        32'h00000000, 32'h0000000F, 32, 3};
    vecs[5]  = '{1'b0, 32'd7,         32'd0,        32'h00000000, 32'h00000000, 32, 1};
    vecs[6]  = '{1'b1, 32'd100,       32'd7,        32'h00000002, 32'h0000000E, 32, 32};
    vecs[7]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32, 32};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32, 1};
    vecs[9]  = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32, 31};
    vecs[10] = '{1'b1, 32'd5,         32'd10,       32'h00000005, 32'h00000000, 32, 32};
    vecs[11] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 32, 32};
    vecs[12] = '{1'b0, 32'h12345678,  32'h00000010, 32'h00000001, 32'h23456780, 32, 5};

    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 64'd0);
    check("rst_lo", lo, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_zex", zero_div_exception, 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 64'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].opv, vecs[i].av, vecs[i].bv, -1, rhi, rlo, lat, bcnt, dcnt, zcnt);
      el = pick_lat(vecs[i].lat_full, vecs[i].lat_early);
      check($sformatf("v%0d_hi", i), rhi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), rlo, vecs[i].elo);
      check($sformatf("v%0d_latency", i), lat, el);
      check($sformatf("v%0d_busy_cycles", i), bcnt, el);
      check($sformatf("v%0d_done_width", i), dcnt, 64'd1);
      check($sformatf("v%0d_zex", i), zcnt, 64'd0);
    end

    // Divide by zero: one-cycle exception, no busy/done, hi/lo untouched
    prev_hi = vecs[NV-1].ehi;
    prev_lo = vecs[NV-1].elo;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd10; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("dz_zex_pulse", zero_div_exception, 64'd1);
    check("dz_busy", busy, 64'd0);
    check("dz_done", done, 64'd0);
    zcnt = 0; bcnt = 0; dcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (zero_div_exception) zcnt++;
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    check("dz_zex_after", zcnt, 64'd0);
    check("dz_busy_after", bcnt, 64'd0);
    check("dz_done_after", dcnt, 64'd0);
    check("dz_hi_kept", hi, prev_hi);
    check("dz_lo_kept", lo, prev_lo);

    // start re-pulsed while running is ignored
    run_op(1'b0, 32'd3, 32'hFFFFFFFB, 1, rhi, rlo, lat, bcnt, dcnt, zcnt);
    check("rs_hi", rhi, 64'hFFFFFFFF);
    check("rs_lo", rlo, 64'hFFFFFFF1);
    check("rs_latency", lat, pick_lat(32, 3));
    check("rs_done_width", dcnt, 64'd1);

    // Asynchronous reset at iteration 10 aborts the divide
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("ab_busy_before", busy, 64'd1);
    reset = 1'b0;
    #1;
    check("ab_hi", hi, 64'd0);
    check("ab_lo", lo, 64'd0);
    check("ab_busy", busy, 64'd0);
    check("ab_done", done, 64'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    bcnt = 0; dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    check("ab_no_busy", bcnt, 64'd0);
    check("ab_no_done", dcnt, 64'd0);

    run_op(1'b1, 32'hFFFFFFF9, 32'd2, -1, rhi, rlo, lat, bcnt, dcnt, zcnt);
    check("post_hi", rhi, 64'hFFFFFFFF);
    check("post_lo", rlo, 64'hFFFFFFFD);
    check("post_latency", lat, 64'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
